tqvp_gera_gray_reader: RTL

TQVP_GERA_GRAY_READER -- requirements
Module: tqvp_gera_gray_reader

---
 rtl/tqvp_gera_gray_reader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/tqvp_gera_gray_reader.sv
// Debounced 4-bit Gray-code position reader with a small register file.
// Define GRAY_READER_ERRCNT_EN to implement the saturating skip-error counter at address 0x2.
module tqvp_gera_gray_reader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = g[2] ^ b[3];
    b[1] = g[1] ^ b[2];
    b[0] = g[0] ^ b[1];
    return b;
  endfunction

  logic [3:0] cand_q, cand_d;
  logic [7:0] stable_q, stable_d;
  logic [7:0] deb_q, deb_d;
  logic [3:0] gray_q, gray_d;
  logic       valid_q, valid_d;
  logic [7:0] pos_q, pos_d;
  logic       err_q, err_d;
  logic       dir_q, dir_d;

  logic [3:0] code_s;
  logic [3:0] b_old_s;
  logic [3:0] b_new_s;
  logic [3:0] delta_s;
  logic       accept_s;
  logic       skip_s;
  logic       wr_status_s;
  logic       wr_pos_s;
  logic       wr_deb_s;
  logic [7:0] errcnt_rd_s;
  logic       unused_ok_s;

  assign code_s      = ui_in[3:0];
  assign unused_ok_s = ^ui_in[7:4];
  assign b_old_s     = gray2bin(gray_q);
  assign b_new_s     = gray2bin(cand_q);
  assign delta_s     = b_new_s - b_old_s;
  assign accept_s    = (cand_q == code_s) && (stable_q == deb_q) && ((cand_q != gray_q) || !valid_q);
  assign wr_status_s = data_write && (address == 4'h0);
  assign wr_pos_s    = data_write && (address == 4'h1);
  assign wr_deb_s    = data_write && (address == 4'h3);

  // Next-state: sampling, accept/step, then register writes (writes beat steps, errors beat clears)
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    gray_d   = gray_q;
    valid_d  = valid_q;
    pos_d    = pos_q;
    err_d    = err_q;
    dir_d    = dir_q;
    deb_d    = deb_q;
    skip_s   = 1'b0;

    if (code_s != cand_q) begin
      cand_d   = code_s;
      stable_d = 8'd0;
    end else if (stable_q < deb_q) begin
      stable_d = stable_q + 8'd1;
    end else begin
      stable_d = stable_q;
    end

    if (accept_s) begin
      gray_d  = cand_q;
      valid_d = 1'b1;
      if (valid_q) begin
        case (delta_s)
          4'd1: begin
            pos_d = pos_q + 8'd1;
            dir_d = 1'b1;
          end
          4'd15: begin
            pos_d = pos_q - 8'd1;
            dir_d = 1'b0;
          end
          default: skip_s = 1'b1;
        endcase
      end else begin
        skip_s = 1'b0;
      end
    end else begin
      gray_d = gray_q;
    end

    if (wr_status_s && data_in[0]) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    if (skip_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end

    if (wr_pos_s) begin
      pos_d = data_in;
    end else if (wr_status_s && data_in[1]) begin
      pos_d = 8'd0;
    end else begin
      pos_d = pos_d;
    end

    if (wr_deb_s) begin
      deb_d    = data_in;
      stable_d = 8'd0;
    end else begin
      deb_d = deb_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q   <= 4'd0;
      stable_q <= 8'd0;
      deb_q    <= 8'h04;
      gray_q   <= 4'd0;
      valid_q  <= 1'b0;
      pos_q    <= 8'd0;
      err_q    <= 1'b0;
      dir_q    <= 1'b0;
    end else begin
      cand_q   <= cand_d;
      stable_q <= stable_d;
      deb_q    <= deb_d;
      gray_q   <= gray_d;
      valid_q  <= valid_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
      dir_q    <= dir_d;
    end
  end

`ifdef GRAY_READER_ERRCNT_EN
  logic [7:0] errcnt_q, errcnt_d;

  // Counter clears first so a coincident skip still counts once
  always_comb begin
    if (wr_status_s && data_in[0]) begin
      errcnt_d = 8'd0;
    end else begin
      errcnt_d = errcnt_q;
    end
    if (skip_s && (errcnt_d != 8'hFF)) begin
      errcnt_d = errcnt_d + 8'd1;
    end else begin
      errcnt_d = errcnt_d;
    end
  end

  // Error counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errcnt_q <= 8'd0;
    end else begin
      errcnt_q <= errcnt_d;
    end
  end

  assign errcnt_rd_s = errcnt_q;
`else
  assign errcnt_rd_s = 8'd0;
`endif

  // Read mux
  always_comb begin
    data_out = 8'd0;
    case (address)
      4'h0:    data_out = {err_q, dir_q, valid_q, 1'b0, b_old_s};
      4'h1:    data_out = pos_q;
      4'h2:    data_out = errcnt_rd_s;
      4'h3:    data_out = deb_q;
      default: data_out = 8'd0;
    endcase
  end

  assign uo_out = pos_q;

endmodule
